// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared widths, defaults and FSM state type for the score keeper
package score_pkg;

   localparam int SCORE_W           = 7;
   localparam int DEFAULT_MAX_SCORE = 99;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAYING,
      S_GAME_OVER
   } score_state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// rtl/rising_edge_detect.sv - one-cycle pulse on each 0->1 transition of a level input
module rising_edge_detect (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Sig,
   output logic o_Edge
);

   logic sig_q;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= i_Sig;
      end
   end

   assign o_Edge = i_Sig & ~sig_q;

endmodule

// File: rtl/score_counter.sv
// rtl/score_counter.sv - saturating game score, session high score and game-over display alternation
module score_counter
   import score_pkg::*;
#(
   parameter int MAX_SCORE     = DEFAULT_MAX_SCORE,
   parameter int TOGGLE_CYCLES = 25_000_000
) (
   input  logic               i_Clk,
   input  logic               i_Rst_L,
   input  logic               i_Start,
   input  logic               i_Point,
   input  logic               i_Game_Over,
   output logic [SCORE_W-1:0] o_Score,
   output logic [SCORE_W-1:0] o_High_Score,
   output logic               o_Showing_High,
   output logic               o_Max_Reached
);

   localparam int                 TOG_W    = $clog2(TOGGLE_CYCLES);
   localparam logic [TOG_W-1:0]   TOG_LAST = TOG_W'(TOGGLE_CYCLES - 1);
   localparam logic [SCORE_W-1:0] MAX_S    = SCORE_W'(MAX_SCORE);

   score_state_t       state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] high_q, high_d;
   logic [TOG_W-1:0]   tog_q, tog_d;
   logic               show_q, show_d;
   logic               point_edge;
   logic [SCORE_W-1:0] score_inc;

   rising_edge_detect u_point_edge (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Sig   (i_Point),
      .o_Edge  (point_edge)
   );

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q <= S_IDLE;
         score_q <= '0;
         high_q  <= '0;
         tog_q   <= '0;
         show_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         high_q  <= high_d;
         tog_q   <= tog_d;
         show_q  <= show_d;
      end
   end

   // Saturating increment; also feeds the high-score compare so a point arriving
   // with game over is counted before the compare.
   assign score_inc = (point_edge && (score_q < MAX_S)) ? score_q + SCORE_W'(1) : score_q;

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      high_d  = high_q;
      tog_d   = tog_q;
      show_d  = show_q;
      case (state_q)
         S_IDLE: begin
            if (i_Start) begin
               state_d = S_PLAYING;
               score_d = '0;
            end
         end
         S_PLAYING: begin
            if (i_Game_Over) begin
               state_d = S_GAME_OVER;
               score_d = score_inc;
               high_d  = (score_inc > high_q) ? score_inc : high_q;
               tog_d   = '0;
               show_d  = 1'b0;
            end else if (i_Start) begin
               score_d = '0;
            end else begin
               score_d = score_inc;
            end
         end
         S_GAME_OVER: begin
            if (i_Start) begin
               state_d = S_PLAYING;
               score_d = '0;
               tog_d   = '0;
               show_d  = 1'b0;
            end else if (tog_q == TOG_LAST) begin
               tog_d  = '0;
               show_d = ~show_q;
            end else begin
               tog_d = tog_q + TOG_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_Score        = show_q ? high_q : score_q;
   assign o_High_Score   = high_q;
   assign o_Showing_High = show_q;
   assign o_Max_Reached  = (score_q == MAX_S);

endmodule
